// File: rtl/cmp_lock_tracker.sv
// rtl/cmp_lock_tracker.sv - lock/unlock hysteresis tracker for 2-bit comparator flags
// Optional saturating gt/lt statistics enabled by defining CMP_LOCK_STATS_EN.
module cmp_lock_tracker #(
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             a_eq_b,
  input  logic             a_gr_b,
  input  logic             a_ls_b,
  output logic             locked,
  output logic             lock_pulse,
  output logic             unlock_pulse,
  output logic             err,
  output logic [1:0]       last_dir,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, RELEASE} state_t;

  localparam logic [7:0] LOCK_V   = 8'(LOCK_N);
  localparam logic [7:0] UNLOCK_V = 8'(UNLOCK_N);

  state_t     state, state_n;
  logic [7:0] run, run_n, miss, miss_n;
  logic       lock_pulse_n, unlock_pulse_n, err_n;
  logic [1:0] last_dir_n;
  logic [2:0] flags;
  logic       legal, illegal, is_eq, is_gt, is_lt;

  assign flags   = {a_eq_b, a_gr_b, a_ls_b};
  assign legal   = in_valid && (flags == 3'b100 || flags == 3'b010 || flags == 3'b001);
  assign illegal = in_valid && !legal;
  assign is_eq   = legal && a_eq_b;
  assign is_gt   = legal && a_gr_b;
  assign is_lt   = legal && a_ls_b;

  assign locked  = (state == LOCKED) || (state == RELEASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= UNLOCKED;
      run          <= 8'd0;
      miss         <= 8'd0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
      err          <= 1'b0;
      last_dir     <= 2'b00;
    end else if (clr) begin
      state        <= UNLOCKED;
      run          <= 8'd0;
      miss         <= 8'd0;
      lock_pulse   <= 1'b0;
      unlock_pulse <= 1'b0;
      err          <= 1'b0;
      last_dir     <= 2'b00;
    end else begin
      state        <= state_n;
      run          <= run_n;
      miss         <= miss_n;
      lock_pulse   <= lock_pulse_n;
      unlock_pulse <= unlock_pulse_n;
      err          <= err_n;
      last_dir     <= last_dir_n;
    end
  end

  // Illegal samples leave legal=0, so the FSM and counters hold automatically.
  always_comb begin
    state_n = state;
    run_n   = run;
    miss_n  = miss;
    if (legal) begin
      case (state)
        UNLOCKED: begin
          if (is_eq) begin
            if (LOCK_N == 1) begin
              state_n = LOCKED;
            end else begin
              state_n = ACQUIRE;
              run_n   = 8'd1;
            end
          end
        end
        ACQUIRE: begin
          if (is_eq) begin
            if (run + 8'd1 == LOCK_V) begin
              state_n = LOCKED;
              run_n   = 8'd0;
            end else begin
              run_n = run + 8'd1;
            end
          end else begin
            state_n = UNLOCKED;
            run_n   = 8'd0;
          end
        end
        LOCKED: begin
          if (!is_eq) begin
            if (UNLOCK_N == 1) begin
              state_n = UNLOCKED;
            end else begin
              state_n = RELEASE;
              miss_n  = 8'd1;
            end
          end
        end
        RELEASE: begin
          if (is_eq) begin
            state_n = LOCKED;
            miss_n  = 8'd0;
          end else if (miss + 8'd1 == UNLOCK_V) begin
            state_n = UNLOCKED;
            miss_n  = 8'd0;
          end else begin
            miss_n = miss + 8'd1;
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    lock_pulse_n   = (state_n == LOCKED) && (state == UNLOCKED || state == ACQUIRE);
    unlock_pulse_n = (state_n == UNLOCKED) && (state == LOCKED || state == RELEASE);
    err_n          = illegal;
    last_dir_n     = last_dir;
    if (is_gt) begin
      last_dir_n = 2'b10;
    end else if (is_lt) begin
      last_dir_n = 2'b01;
    end
  end

`ifdef CMP_LOCK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
    end else if (clr) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
    end else begin
      if (is_gt && gt_cnt != {CNT_W{1'b1}}) gt_cnt <= gt_cnt + 1'b1;
      if (is_lt && lt_cnt != {CNT_W{1'b1}}) lt_cnt <= lt_cnt + 1'b1;
    end
  end
`else
  assign gt_cnt = '0;
  assign lt_cnt = '0;
`endif

endmodule
